// File: rtl/ex_div_ctrl_if.sv
// ex_div_ctrl_if: request/result bundle between the EX stage and the divide sequencer.
//   master : EX side. Drives the request, operands, cancel and MEM_allow_in.
//            Receives quotient, remainder, done and busy.
//   slave  : divider side, with the directions reversed.
interface ex_div_ctrl_if #(
   parameter int unsigned WIDTH = 32
);
   logic             div_req;
   logic             div_signed;
   logic [WIDTH-1:0] div_src1;
   logic [WIDTH-1:0] div_src2;
   logic             div_cancel;
   logic             MEM_allow_in;
   logic [WIDTH-1:0] div_quot;
   logic [WIDTH-1:0] div_rem;
   logic             div_done;
   logic             div_busy;

   modport master (
      output div_req, div_signed, div_src1, div_src2, div_cancel, MEM_allow_in,
      input  div_quot, div_rem, div_done, div_busy
   );

   modport slave (
      input  div_req, div_signed, div_src1, div_src2, div_cancel, MEM_allow_in,
      output div_quot, div_rem, div_done, div_busy
   );
endinterface

// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: multi-cycle radix-2 restoring divide sequencer for the EX stage.
// One quotient bit is produced per cycle, so an operation takes WIDTH cycles.
// Both quotient and remainder are returned, and EX selects between them.
// EX may advance when ~is_div | div_done.
//   clk   : pipeline clock
//   reset : asynchronous active-high reset
//   bus   : ex_div_ctrl_if.slave, which carries the following signals:
//           div_req/div_signed/div_src1/div_src2 are the request and its operands.
//           div_cancel is the flush input and aborts any operation.
//           MEM_allow_in is the downstream accept.
//           div_quot/div_rem/div_done/div_busy are the results and the status.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor goes straight from IDLE to DONE.
// The results are the same as those of the full iteration.
module ex_div_ctrl #(
   parameter int unsigned WIDTH = 32
) (
   input  logic          clk,
   input  logic          reset,
   ex_div_ctrl_if.slave  bus
);
   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e           r_state;
   state_e           w_state_next;
   logic             w_start;

   logic [WIDTH-1:0] r_dvd;    // dividend magnitude, shifted out MSB first
   logic [WIDTH-1:0] r_dsr;    // divisor magnitude
   logic [WIDTH-1:0] r_rem;    // partial remainder (magnitude)
   logic [WIDTH-1:0] r_quot;   // quotient magnitude
   logic [CntW-1:0]  r_cnt;
   logic             r_qsign;
   logic             r_rsign;

   logic             w_src1_neg;
   logic             w_src2_neg;
   logic [WIDTH-1:0] w_abs1;
   logic [WIDTH-1:0] w_abs2;
   logic [WIDTH:0]   w_part;
   logic [WIDTH:0]   w_diff;
   logic             w_ge;
   logic             w_last;

   // 0x80..0 negates to itself. That result is still the right magnitude when read as unsigned.
   assign w_src1_neg = bus.div_signed & bus.div_src1[WIDTH-1];
   assign w_src2_neg = bus.div_signed & bus.div_src2[WIDTH-1];
   assign w_abs1     = w_src1_neg ? ({WIDTH{1'b0}} - bus.div_src1) : bus.div_src1;
   assign w_abs2     = w_src2_neg ? ({WIDTH{1'b0}} - bus.div_src2) : bus.div_src2;

   // A borrow out of the (WIDTH+1)-bit subtract means the remainder is below the divisor.
   assign w_part = {r_rem, r_dvd[WIDTH-1]};
   assign w_diff = w_part - {1'b0, r_dsr};
   assign w_ge   = ~w_diff[WIDTH];
   assign w_last = (r_cnt == CntW'(WIDTH - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      if (bus.div_cancel) begin
         w_state_next = StIdle;
      end else begin
         case (r_state)
            StIdle: begin
               if (bus.div_req) begin
                  w_start = 1'b1;
`ifdef DIV_ZERO_FAST_EN
                  w_state_next = (w_abs2 == '0) ? StDone : StCalc;
`else
                  w_state_next = StCalc;
`endif
               end
            end
            StCalc: begin
               if (w_last) w_state_next = StDone;
            end
            StDone: begin
               if (bus.MEM_allow_in) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dvd   <= '0;
         r_dsr   <= '0;
         r_rem   <= '0;
         r_quot  <= '0;
         r_cnt   <= '0;
         r_qsign <= 1'b0;
         r_rsign <= 1'b0;
      end else if (w_start) begin
         r_dvd   <= w_abs1;
         r_dsr   <= w_abs2;
         r_cnt   <= '0;
         r_qsign <= (bus.div_src1[WIDTH-1] ^ bus.div_src2[WIDTH-1]) & bus.div_signed;
         r_rsign <= w_src1_neg;
`ifdef DIV_ZERO_FAST_EN
         // These are the values that WIDTH steps against a zero divisor would produce.
         if (w_abs2 == '0) begin
            r_rem  <= w_abs1;
            r_quot <= '1;
         end else begin
            r_rem  <= '0;
            r_quot <= '0;
         end
`else
         r_rem  <= '0;
         r_quot <= '0;
`endif
      end else if ((r_state == StCalc) && !bus.div_cancel) begin
         r_dvd  <= {r_dvd[WIDTH-2:0], 1'b0};
         r_rem  <= w_ge ? w_diff[WIDTH-1:0] : w_part[WIDTH-1:0];
         r_quot <= {r_quot[WIDTH-2:0], w_ge};
         r_cnt  <= r_cnt + CntW'(1);
      end
   end

   assign bus.div_quot = r_qsign ? ({WIDTH{1'b0}} - r_quot) : r_quot;
   assign bus.div_rem  = r_rsign ? ({WIDTH{1'b0}} - r_rem) : r_rem;
   assign bus.div_done = (r_state == StDone);
   assign bus.div_busy = (r_state != StIdle);
endmodule

// File: tb/tb_ex_div_ctrl.sv
module tb_ex_div_ctrl;
   localparam int unsigned WIDTH = 32;
`ifdef DIV_ZERO_FAST_EN
   localparam bit Fast = 1'b1;
`else
   localparam bit Fast = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   ex_div_ctrl_if #(.WIDTH(WIDTH)) bus ();

   ex_div_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one divide and wait for div_done (bounded).
   // Check the latency and the results, stall for 'stall' cycles, then accept with div_req still high.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input int stall, input logic [31:0] eq, input logic [31:0] er,
                          input string tag);
      int lat;
      int exp_lat;
      exp_lat = (Fast && (b == 32'h0)) ? 1 : WIDTH + 1;
      @(negedge clk);
      bus.div_req      = 1'b1;
      bus.div_src1     = a;
      bus.div_src2     = b;
      bus.div_signed   = sgn;
      bus.MEM_allow_in = (stall == 0);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            // The operands were latched in IDLE, so these new values must have no effect.
            bus.div_src1 = 32'h1234_5678;
            bus.div_src2 = 32'h1;
         end
      end while (!bus.div_done && lat < 60);
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " done"}, 32'(bus.div_done), 32'h1);
      check({tag, " busy"}, 32'(bus.div_busy), 32'h1);
      check({tag, " quot"}, bus.div_quot, eq);
      check({tag, " rem"}, bus.div_rem, er);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check({tag, " stall done"}, 32'(bus.div_done), 32'h1);
         check({tag, " stall quot"}, bus.div_quot, eq);
         check({tag, " stall rem"}, bus.div_rem, er);
      end
      bus.MEM_allow_in = 1'b1;
      @(negedge clk);
      check({tag, " accept done"}, 32'(bus.div_done), 32'h0);
      check({tag, " accept busy"}, 32'(bus.div_busy), 32'h0);
      bus.div_req = 1'b0;
      @(negedge clk);
      check({tag, " no restart"}, 32'(bus.div_busy), 32'h0);
   endtask

   initial begin
      int seen;
      reset            = 1'b1;
      bus.div_req      = 1'b0;
      bus.div_signed   = 1'b0;
      bus.div_src1     = '0;
      bus.div_src2     = '0;
      bus.div_cancel   = 1'b0;
      bus.MEM_allow_in = 1'b1;

      @(negedge clk);
      check("reset quot", bus.div_quot, 32'h0);
      check("reset rem", bus.div_rem, 32'h0);
      check("reset done", 32'(bus.div_done), 32'h0);
      check("reset busy", 32'(bus.div_busy), 32'h0);
      reset = 1'b0;

      run_div(32'd100, 32'd7, 1'b0, 0, 32'd14, 32'd2, "u100/7");
      run_div(32'hFFFF_FFF9, 32'h2, 1'b1, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "s-7/2");
      run_div(32'h7, 32'hFFFF_FFFE, 1'b1, 0, 32'hFFFF_FFFD, 32'h1, "s7/-2");
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 32'h8000_0000, 32'h0, "sovf");
      run_div(32'd5, 32'd0, 1'b0, 0, 32'hFFFF_FFFF, 32'd5, "u5/0");
      run_div(32'hFFFF_FFFB, 32'd0, 1'b1, 0, 32'h1, 32'hFFFF_FFFB, "s-5/0");

      // Cancel together with a request in IDLE: no start.
      @(negedge clk);
      bus.div_req    = 1'b1;
      bus.div_cancel = 1'b1;
      bus.div_src1   = 32'd50;
      bus.div_src2   = 32'd5;
      bus.div_signed = 1'b0;
      @(negedge clk);
      check("cancel+req busy", 32'(bus.div_busy), 32'h0);
      bus.div_req    = 1'b0;
      bus.div_cancel = 1'b0;

      // Cancel in CALC cycle 10.
      @(negedge clk);
      bus.div_req  = 1'b1;
      bus.div_src1 = 32'd100;
      bus.div_src2 = 32'd7;
      repeat (10) @(negedge clk);
      check("pre-cancel busy", 32'(bus.div_busy), 32'h1);
      bus.div_cancel = 1'b1;
      bus.div_req    = 1'b0;
      @(negedge clk);
      bus.div_cancel = 1'b0;
      check("cancel busy", 32'(bus.div_busy), 32'h0);
      check("cancel done", 32'(bus.div_done), 32'h0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.div_done) seen = 1;
      end
      check("cancel never done", 32'(seen), 32'h0);
      run_div(32'd9, 32'd3, 1'b0, 0, 32'd3, 32'd0, "u9/3 after cancel");

      // Backpressure: hold for 5 cycles in DONE.
      run_div(32'd1001, 32'd10, 1'b0, 5, 32'd100, 32'd1, "u1001/10 stall");

      // Asynchronous reset between clock edges, mid-CALC (partial quot=10, rem=1 here).
      @(negedge clk);
      bus.div_req    = 1'b1;
      bus.div_src1   = 32'hFFFF_FFFF;
      bus.div_src2   = 32'd3;
      bus.div_signed = 1'b0;
      repeat (6) @(negedge clk);
      bus.div_req = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("async reset quot", bus.div_quot, 32'h0);
      check("async reset rem", bus.div_rem, 32'h0);
      check("async reset done", 32'(bus.div_done), 32'h0);
      check("async reset busy", 32'(bus.div_busy), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("post reset busy", 32'(bus.div_busy), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ex_div_ctrl.md
Name: ex_div_ctrl

Overview:
- Multi-cycle integer divide sequencer for the EX stage.
- Owns an iterative radix-2 restoring divider and its FSM.
- Produces the EX stall/ready term, so that EX_ready_go = ~is_div | div_done.
- Serves div.w/mod.w/div.wu/mod.wu. The quotient/remainder select is done in EX by alu_op; this block returns both results.

Parameters:
WIDTH, 32, operand/result width in bits; the iteration count equals WIDTH.

Ports:
clk  input  1  pipeline clock
reset  input  1  asynchronous active-high reset
div_req  input  1  EX_valid & EX instruction is a divide; level, held until accepted
div_signed  input  1  1 = two's-complement divide, 0 = unsigned
div_src1  input  WIDTH  dividend (rj_value)
div_src2  input  WIDTH  divisor (rkd_value)
div_cancel  input  1  flush of the EX instruction; aborts any operation
MEM_allow_in  input  1  downstream accepts EX output this cycle
div_quot  output  WIDTH  quotient
div_rem  output  WIDTH  remainder
div_done  output  1  results valid; EX may advance
div_busy  output  1  FSM in CALC or DONE

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, iteration count=0, div_quot=0, div_rem=0, div_done=0, div_busy=0.
- FSM states and transitions:
  - IDLE: on div_req & ~div_cancel, latch the operands and go to CALC.
    - Latched values: the absolute values when div_signed, the raw values otherwise.
    - Also latched: the quotient sign = src1[MSB]^src2[MSB] & div_signed, and the remainder sign = src1[MSB] & div_signed.
  - CALC: one shift-subtract step per cycle; the count runs 0..WIDTH-1.
    - Step: partial remainder = {rem, dvd[MSB]}, the dividend shifts left by 1, and the remainder is compared against the divisor.
    - If the remainder is >= the divisor, subtract and set the quotient bit to 1; otherwise the quotient bit is 0.
    - After the WIDTH-th step, go to DONE.
  - DONE: div_done=1. Outputs carry the sign-corrected results: negate the quotient if its sign bit is set; negate the remainder if the remainder sign is set.
    - On MEM_allow_in, go to IDLE.
    - div_req is still high in that accept cycle (old instruction) and must not start a new op; IDLE samples div_req from the next cycle.
- Latency: req sampled in IDLE at cycle 0; CALC occupies cycles 1..WIDTH; div_done=1 in cycle WIDTH+1 (cycle 33 for WIDTH=32) and holds until accept.
- div_done is registered (a state decode only), not combinational from any input.
- div_busy = (state != IDLE).
- div_cancel has priority over every other event in every state: next cycle the state is IDLE and div_done=0. The result registers keep their previous contents; there is no other side effect.
  - div_cancel and div_req high in the same IDLE cycle: no start.
- Operands are sampled once, in IDLE. Changes on div_src1/div_src2 during CALC/DONE are ignored.
- Divide by zero (no trap), taken from the natural algorithm result:
  - unsigned: quot=all ones, rem=src1
  - signed: quot = src1<0 ? 1 : all ones; rem=src1
- Signed overflow: src1=0x80000000, src2=0xFFFFFFFF gives quot=0x80000000, rem=0.
- The magnitude negation for 0x80000000 yields 0x80000000 (wrap); this is correct in unsigned arithmetic.
- Stall while in DONE with MEM_allow_in=0: outputs stay stable and div_done stays 1.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined: in IDLE, when div_req and the divisor (after abs) is 0, go directly to DONE.
  - The result is the same as the divide-by-zero rule above.
  - div_done rises at cycle 1 instead of cycle WIDTH+1.
- Undefined: divide-by-zero runs the full WIDTH iterations like any other operand.

Test Plan:
- Unsigned 100/7, div_signed=0, MEM_allow_in=1: div_done is 0 for cycles 1-32 and 1 in cycle 33; quot=14, rem=2; the next cycle is IDLE with div_done=0.
- Signed -7/2 (0xFFFFFFF9/0x2): quot=0xFFFFFFFD (-3), rem=0xFFFFFFFF (-1).
- Signed 7/-2: quot=-3, rem=1.
- Signed 0x80000000/0xFFFFFFFF: quot=0x80000000, rem=0.
- Divide by zero: unsigned 5/0 gives quot=0xFFFFFFFF, rem=5 at cycle 33. With DIV_ZERO_FAST_EN the same values appear at cycle 1.
  - Signed -5/0: quot=1, rem=0xFFFFFFFB.
- div_cancel pulse at CALC cycle 10: IDLE next cycle, div_busy=0, div_done never asserts. A new req 9/3 issued afterwards returns quot=3, rem=0 after a full WIDTH+1 cycles.
- Backpressure: hold MEM_allow_in=0 for 5 cycles in DONE; div_done and the results stay stable. Raise MEM_allow_in with div_req still high; the block returns to IDLE and does not restart until div_req is sampled again in IDLE.
- Asynchronous reset asserted mid-CALC, between clock edges: outputs go to 0 immediately, without waiting for a clock edge.
